// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner that fetches words from imem and buffers {pc, instr} for decode.
module instruction_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [XLEN-1:0] pc_q [FIFO_DEPTH];
    logic [31:0]     instr_q [FIFO_DEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d, out_q, out_d, discard_q, discard_d;
    logic [0:0]      state_q, state_d;
    logic [CW:0]     used;
    logic            empty, accept, rsp, push, pop;

    assign empty = count_q == '0;
    assign target = redirect_pc & ~XLEN'(3);
    assign if_valid = ~reset & ~empty & ~redirect_valid;
    assign pop = if_valid & if_ready;
    // the slot freed by this cycle's pop counts as credit, which keeps a 1-cycle memory streaming
    assign used = {1'b0, out_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    assign imem_req_valid = ~reset & ~redirect_valid & (used < DEPTH_W);
    assign imem_req_addr = fetch_pc_q;
    assign accept = imem_req_valid & imem_req_ready;
    // a response with nothing outstanding can only belong to a pre-reset request
    assign rsp = imem_rsp_valid & (out_q != '0);
    assign push = rsp & ~redirect_valid & (state_q == RUN);
    assign if_instr = empty ? NOP : instr_q[rd_q];
    assign if_pc = empty ? '0 : pc_q[rd_q];

    always_comb begin
        fetch_pc_d = redirect_valid ? target : accept ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        out_d = out_q + CW'(accept) - CW'(rsp);
        discard_d = redirect_valid ? out_d : discard_q - CW'(rsp && state_q == DRAIN);
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        wr_d = redirect_valid ? '0 : wr_q + AW'(push);
        rd_d = redirect_valid ? '0 : rd_q + AW'(pop);
        state_d = discard_d != '0 ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q <= '0;
            discard_q <= '0;
            count_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            state_q <= RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q <= out_d;
            discard_q <= discard_d;
            count_q <= count_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_q] <= rsp_pc_q;
            instr_q[wr_q] <= imem_rsp_data;
        end
    end
endmodule
